// File: rtl/ppu_pixel_fifo.sv
// Pixel FIFO: row-wide push, single-pixel pop, in-place overlay merge on the oldest row.
// Zero-latency head output; push/merge/pop stall via push_ready/merge_ready/pop_valid, illegal requests set sticky err.
module ppu_pixel_fifo #(
    parameter int PX_W   = 2,
    parameter int ATTR_W = 3,
    parameter int ROW_PX = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       flush,
    input  logic                       push_row,
    input  logic [ROW_PX*PX_W-1:0]     push_color,
    input  logic [ATTR_W-1:0]          push_attr,
    output logic                       push_ready,
    input  logic                       merge_en,
    input  logic [ROW_PX*PX_W-1:0]     merge_color,
    input  logic [ATTR_W-1:0]          merge_attr,
    output logic                       merge_ready,
    input  logic                       pop,
    output logic                       pop_valid,
    output logic [PX_W-1:0]            pop_color,
    output logic [ATTR_W-1:0]          pop_attr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PX_W + ATTR_W;

    logic [EW-1:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          non_empty;
    logic          push_fire;
    logic          merge_fire;
    logic          pop_fire;
    logic          bad_req;

    // Extra pointer bit makes the difference a true occupancy, including the full case.
    assign count     = wr_ptr - rd_ptr;
    assign non_empty = (count != '0);

    assign push_ready  = (CW'(DEPTH) - count) >= CW'(ROW_PX);
    assign merge_ready = count >= CW'(ROW_PX);
    assign pop_valid   = non_empty && !merge_en;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign pop_color = non_empty ? head[EW-1:ATTR_W] : '0;
    assign pop_attr  = non_empty ? head[ATTR_W-1:0]  : '0;

    assign push_fire  = push_row && push_ready  && !flush;
    assign merge_fire = merge_en && merge_ready && !flush;
    assign pop_fire   = pop      && pop_valid   && !flush;
    assign bad_req    = (push_row && !push_ready) || (merge_en && !merge_ready) || (pop && !non_empty);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + CW'(ROW_PX);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (bad_req) begin
                err <= 1'b1;
            end
        end
    end

    // Merge touches only the oldest row, push only free slots, so the two never collide.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            for (int i = 0; i < ROW_PX; i++) begin
                mem[wr_ptr[AW-1:0] + AW'(i)] <= {push_color[(ROW_PX-1-i)*PX_W +: PX_W], push_attr};
            end
        end
        if (merge_fire) begin
            for (int i = 0; i < ROW_PX; i++) begin
                if ((mem[rd_ptr[AW-1:0] + AW'(i)][EW-1:ATTR_W] == '0) &&
                    (merge_color[(ROW_PX-1-i)*PX_W +: PX_W] != '0)) begin
                    mem[rd_ptr[AW-1:0] + AW'(i)] <= {merge_color[(ROW_PX-1-i)*PX_W +: PX_W], merge_attr};
                end
            end
        end
    end

endmodule

// File: doc/ppu_pixel_fifo.md
Name: ppu_pixel_fifo

Overview:
Parametrised pixel FIFO for the PPU DRAW-mode pipeline; successor to the generic single-word FIFO.
- Accepts a full decoded tile row (ROW_PX pixels) in one push and emits one pixel per pop.
- Supports in-place sprite overlay merge on the oldest row, synchronous flush (new line / window hit) and occupancy reporting.
- One instance serves as the background FIFO; the sprite path feeds it through the merge port.

Parameters:
PX_W, 2, bits per pixel colour index
ATTR_W, 3, per-pixel attribute bits (palette select, priority, source)
ROW_PX, 8, pixels per pushed/merged row
DEPTH, 16, storage entries; power of two, multiple of ROW_PX, >= 2*ROW_PX

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents and error flags
push_row  in  1  write one row when push_ready
push_color  in  ROW_PX*PX_W  row colours; MS slice = leftmost pixel (popped first)
push_attr  in  ATTR_W  attribute applied to all ROW_PX pixels of the row
push_ready  out  1  free entries >= ROW_PX
merge_en  in  1  overlay onto oldest ROW_PX entries
merge_color  in  ROW_PX*PX_W  overlay colours, same ordering as push_color
merge_attr  in  ATTR_W  attribute written to replaced entries
merge_ready  out  1  count >= ROW_PX
pop  in  1  consume head pixel
pop_valid  out  1  head pixel valid and pop accepted this cycle
pop_color  out  PX_W  head pixel colour
pop_attr  out  ATTR_W  head pixel attribute
count  out  $clog2(DEPTH)+1  current occupancy
err  out  1  sticky: illegal push, merge or pop seen

Behaviour:
- Reset (rstN low, async): read/write pointers 0, count 0, err 0. Storage contents are don't-care. Outputs: push_ready 1, merge_ready 0, pop_valid 0, pop_color 0, pop_attr 0.
- Storage: DEPTH entries of PX_W+ATTR_W bits. Pointers are $clog2(DEPTH)+1 bits, wrap modulo DEPTH, with an extra bit for full/empty disambiguation.
- Combinational outputs:
  - push_ready = (DEPTH-count) >= ROW_PX.
  - merge_ready = count >= ROW_PX.
  - pop_valid = (count != 0) && !merge_en.
  - pop_color/pop_attr show the head entry when count != 0, else 0. Zero latency.
- Push: on push_row && push_ready, write ROW_PX entries at wrPtr..wrPtr+ROW_PX-1 (wrapping) in left-to-right order. wrPtr += ROW_PX; count += ROW_PX.
- Pop: on pop && pop_valid, rdPtr += 1 and count -= 1.
- Merge: on merge_en && merge_ready, for each i in 0..ROW_PX-1, entry rdPtr+i is replaced by {merge_color[i], merge_attr} iff stored colour == 0 and merge colour != 0. Otherwise the entry is unchanged. Pointers and count are unchanged. A pop in the same cycle is not accepted (pop_valid is 0).
- Simultaneous push + pop: both happen; count += ROW_PX-1. push_ready is judged on count before the pop.
- Simultaneous push + merge: both happen. The merge sees only pre-push entries; the required condition count >= ROW_PX guarantees disjoint ranges.
- Flush: priority over push, pop and merge in the same cycle. Next cycle: pointers 0, count 0, err 0.
- Errors, all ignored functionally, each setting err (held until flush or reset):
  - push_row while !push_ready
  - merge_en while !merge_ready
  - pop while count == 0
- Reset mid-operation: immediate return to reset state regardless of pending push, pop or merge.

Test Plan:
- Reset, then push row colours {3,2,1,0,0,1,2,3}, attr 3'b001. Pop 8 cycles -> pop_color sequence 3,2,1,0,0,1,2,3, pop_attr 1 each; count 8 down to 0; pop_valid drops after the 8th pop.
- Push 2 rows (count 16) -> push_ready 0. A third push_row -> ignored, count stays 16, err=1. Flush -> count 0, err 0, push_ready 1.
- Row {0,1,0,2,0,0,3,0} queued; merge {2,2,2,2,0,0,0,1}, attr 3'b100 -> pops give 2/100, 1/001, 2/100, 2/001, 0, 0, 3/001, 1/100. A pop asserted during the merge cycle -> not accepted, count stays 8.
- Count 8, push_row + pop same cycle -> count 15; head advances by one; new row appended after old tail. Run across pointer wrap (20 rows, continuous pop) -> output ordering intact, no err.
- Pop on empty FIFO -> err 1, count stays 0. Merge with count 4 -> no entry change, err 1.
- Assert rstN low mid-push with count 8 -> count 0, pop_valid 0, err 0 asynchronously. After release, push accepted on the first edge.
